// File: rtl/nbin_zfnaf_writer.sv
// nbin_zfnaf_writer: zero-free encoder and write controller feeding per-lane NBin/offset buffers.
// Optional build macro ZF_THRESHOLD_EN adds i_threshold; lanes with |value| below it are dropped like zeros.
module nbin_zfnaf_writer #(
    parameter int N         = 16,
    parameter int Tn        = 16,
    parameter int OFFSET_SZ = 4,
    parameter int ADDR_SZ   = 6,
    parameter int NUM_WORDS = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [Tn*N-1:0]           i_data,
    input  logic                      i_last,
    input  logic [Tn-1:0]             i_pop,
`ifdef ZF_THRESHOLD_EN
    input  logic [N-1:0]              i_threshold,
`endif
    output logic [Tn*N-1:0]           o_nbin_data,
    output logic [Tn*OFFSET_SZ-1:0]   o_offset_data,
    output logic [Tn-1:0]             o_wen,
    output logic [Tn-1:0]             o_off_wen,
    output logic [Tn*ADDR_SZ-1:0]     o_addr,
    output logic [Tn*ADDR_SZ-1:0]     o_off_wr_addr,
    output logic [Tn*(ADDR_SZ+1)-1:0] o_count
);
    localparam int BRICK = 2**OFFSET_SZ;

    logic                 accept;
    logic                 brick_end;
    logic [OFFSET_SZ-1:0] offset;
    logic [Tn-1:0]        seen;
    logic [Tn-1:0]        nz;
    logic [Tn-1:0]        wr;
    logic [Tn-1:0]        not_full;

    assign accept    = i_valid & o_ready;
    assign brick_end = i_last | (offset == OFFSET_SZ'(BRICK-1));
    assign o_ready   = ~rst & (&not_full);

    // Shared brick offset plus per-lane flag recording whether the lane already got a real entry this brick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset <= '0;
            seen   <= '0;
        end else if (accept) begin
            offset <= brick_end ? '0 : offset + 1'b1;
            seen   <= brick_end ? '0 : seen | nz;
        end
    end

    for (genvar i = 0; i < Tn; i++) begin : g_lane
        logic [N-1:0]         val;
        logic [ADDR_SZ-1:0]   wr_ptr;
        logic [ADDR_SZ:0]     count;
        logic                 pop_eff;
        logic                 wen_q;
        logic                 off_wen_q;
        logic [N-1:0]         data_q;
        logic [OFFSET_SZ-1:0] off_q;
        logic [ADDR_SZ-1:0]   addr_q;

        assign val = i_data[i*N +: N];
`ifdef ZF_THRESHOLD_EN
        logic [N-1:0] mag;
        assign mag   = val[N-1] ? -val : val;
        assign nz[i] = (val != '0) && (mag >= i_threshold);
`else
        assign nz[i] = val != '0;
`endif
        // A lane with nothing surviving in a brick still gets one zero filler so the consumer sees every brick
        assign wr[i]       = accept & (nz[i] | (brick_end & ~seen[i]));
        assign pop_eff     = i_pop[i] & (count != '0);
        assign not_full[i] = count < (ADDR_SZ+1)'(NUM_WORDS);

        assign o_count[i*(ADDR_SZ+1) +: ADDR_SZ+1]  = count;
        assign o_wen[i]                              = wen_q;
        assign o_off_wen[i]                          = off_wen_q;
        assign o_nbin_data[i*N +: N]                 = data_q;
        assign o_offset_data[i*OFFSET_SZ +: OFFSET_SZ] = off_q;
        assign o_addr[i*ADDR_SZ +: ADDR_SZ]          = addr_q;
        assign o_off_wr_addr[i*ADDR_SZ +: ADDR_SZ]   = addr_q;

        // Circular write pointer and occupancy; a write and an effective pop in the same cycle cancel out
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr[i])
                    wr_ptr <= (wr_ptr == ADDR_SZ'(NUM_WORDS-1)) ? '0 : wr_ptr + 1'b1;
                if (wr[i] & ~pop_eff)
                    count <= count + 1'b1;
                else if (~wr[i] & pop_eff)
                    count <= count - 1'b1;
            end
        end

        // Registered write port; reset forces the active-low enable high so no pending write survives
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wen_q     <= 1'b1;
                off_wen_q <= 1'b0;
                data_q    <= '0;
                off_q     <= '0;
                addr_q    <= '0;
            end else begin
                wen_q     <= ~wr[i];
                off_wen_q <= wr[i];
                if (wr[i]) begin
                    data_q <= nz[i] ? val : '0;
                    off_q  <= offset;
                    addr_q <= wr_ptr;
                end
            end
        end
    end
endmodule
